spm_1p_arbiter: RTL and testbench
=================================

// Module: spm_1p_arbiter
// PURPOSE
//   Shares one single-port SPM (spm_1p_adv-style valid/ready request, rvalid response) between
//   NumPorts requesters. Round-robin arbitration, zero added request latency. In-order response
//   routing through an ID FIFO sized for the SPM's configurable read latency. Sits between
//   cluster-local masters (core LSU, DMA, accelerator streamers) and the SPM macro.
// PARAMETERS
//   NumPorts       4    number of requester ports (>=1)
//   AddrWidth      9    word address width
//   DataWidth      32   data width
//   BeWidth        4    byte-enable width
//   MaxOutstanding 4    ID FIFO depth; set >= SPM latency+1 for full throughput (>=1)
// PORTS
//   clk_i          in   1              clock
//   rst_ni         in   1              asynchronous reset, active-low
//   req_valid_i    in   NumPorts       per-port request valid
//   req_ready_o    out  NumPorts       per-port request grant
//   req_we_i       in   NumPorts       per-port write enable
//   req_addr_i     in   NumPorts*AW    per-port address, port p at [p*AW+:AW]
//   req_wdata_i    in   NumPorts*DW    per-port write data
//   req_be_i       in   NumPorts*BW    per-port byte enable
//   rsp_valid_o    out  NumPorts       per-port response valid (reads and writes)
//   rsp_rdata_o    out  DW             read data, broadcast to all ports
//   rsp_rerror_o   out  2              {uncorrectable, correctable}, broadcast
//   mem_valid_o    out  1              SPM request valid
//   mem_ready_i    in   1              SPM request ready
//   mem_we_o       out  1              SPM write enable
//   mem_addr_o     out  AW             SPM address
//   mem_wdata_o    out  DW             SPM write data
//   mem_be_o       out  BW             SPM byte enable
//   mem_rvalid_i   in   1              SPM response valid (one per accepted request)
//   mem_rdata_i    in   DW             SPM read data
//   mem_rerror_i   in   2              SPM error flags
//   spurious_rsp_o out  1              registered pulse: mem_rvalid_i arrived with no outstanding ID
//   outstanding_o  out  clog2(MO+1)    current ID FIFO fill level
// BEHAVIOUR
//   Reset: rr pointer = 0, FIFO empty, outstanding_o = 0, spurious_rsp_o = 0.
//     All of req_ready_o, rsp_valid_o and mem_valid_o are 0 while FIFO is empty and no req_valid_i is set.
//   Arbitration (combinational, same cycle):
//     - Candidate = first port p with req_valid_i[p], scanning from rr pointer upward with wrap.
//     - mem_valid_o = any req_valid_i && !fifo_full. Candidate's we/addr/wdata/be are muxed to mem_*.
//     - req_ready_o[cand] = mem_valid_o && mem_ready_i. All other ready bits are 0.
//     - Request data on mem_* stays stable while the candidate is unchanged. The rr pointer moves only on handshake.
//   Handshake (mem_valid_o && mem_ready_i):
//     - push candidate index into the ID FIFO;
//     - rr pointer <= (cand+1) mod NumPorts.
//     - Without a handshake, the pointer holds and the candidate may change as valids change.
//   Full: fifo_full blocks grants even if mem_rvalid_i pops in the same cycle. There is no comb path rvalid->ready.
//   Responses (combinational, zero latency):
//     - rsp_valid_o[head] = mem_rvalid_i && !fifo_empty, where head = FIFO head ID; pop on that condition.
//     - rsp_rdata_o and rsp_rerror_o pass through. rsp_rerror_o is forced 0 when no rsp_valid_o bit is set.
//   Simultaneous push+pop: count unchanged, head advances, new ID written at tail; legal at any fill level < full.
//   Spurious: mem_rvalid_i && fifo_empty -> no rsp_valid_o; spurious_rsp_o = 1 next cycle for 1 cycle; FIFO untouched.
//   Responses return in grant order; there is no response backpressure (requesters must always accept).
//   Reset mid-operation: FIFO and pointer clear immediately. Responses in flight at reset are dropped and flagged spurious if they arrive later.
//   NumPorts==1: pointer is a constant 0 and arbitration degenerates to a pass-through plus the FIFO.
// TESTING
//   1. Reset, no valids -> all ready/rsp_valid 0, outstanding_o=0; mem_valid_o=0.
//   2. Ports 0..3 all valid continuously, mem_ready_i=1, latency 1 -> grants 0,1,2,3,0 on consecutive
//      cycles; rsp_valid_o one-hot 0001,0010,0100,1000 one cycle later; read data matches.
//   3. MaxOutstanding=2, mem_rvalid_i held 0 -> exactly 2 grants, then ready=0 with outstanding_o=2;
//      single rvalid -> ready still 0 that cycle, grant resumes next cycle.
//   4. Port 2 writes 0xDEADBEEF be=4'b0011 to addr 5, port 1 then reads addr 5 -> port 1 rdata=0x0000BEEF;
//      each port sees exactly one rsp_valid.
//   5. mem_rvalid_i pulse with empty FIFO -> no rsp_valid_o; spurious_rsp_o=1 for exactly one cycle.
//   6. Assert rst_ni low with 3 outstanding, release, then feed 3 rvalids -> no rsp_valid_o;
//      3 spurious pulses; next request is granted to port 0.

Source files
------------

// File: rtl/spm_1p_arbiter.sv
// Round-robin arbiter sharing one single-port SPM between NumPorts requesters.
// Responses are routed back in grant order through an ID FIFO.
module spm_1p_arbiter #(
    parameter int unsigned NumPorts       = 4,
    parameter int unsigned AddrWidth      = 9,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned BeWidth        = 4,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1),
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumPorts-1:0]           req_valid_i,
    output logic [NumPorts-1:0]           req_ready_o,
    input  logic [NumPorts-1:0]           req_we_i,
    input  logic [NumPorts*AddrWidth-1:0] req_addr_i,
    input  logic [NumPorts*DataWidth-1:0] req_wdata_i,
    input  logic [NumPorts*BeWidth-1:0]   req_be_i,
    output logic [NumPorts-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic [1:0]                    rsp_rerror_o,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [BeWidth-1:0]            mem_be_o,
    input  logic                          mem_rvalid_i,
    input  logic [DataWidth-1:0]          mem_rdata_i,
    input  logic [1:0]                    mem_rerror_i,
    output logic                          spurious_rsp_o,
    output logic [CntWidth-1:0]           outstanding_o
);

    logic [IdWidth-1:0]  rr_q;
    logic [IdWidth-1:0]  cand;
    logic [IdWidth-1:0]  idx;
    logic [IdWidth-1:0]  head;
    logic                found;
    logic                any_valid;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [IdWidth-1:0]  ids_q [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                spurious_q;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid port at or above the rr pointer, wrapping around.
    always_comb begin
        cand  = rr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            idx = IdWidth'((int'(rr_q) + i) % NumPorts);
            if (!found && req_valid_i[idx]) begin
                cand  = idx;
                found = 1'b1;
            end
        end
    end

    assign any_valid  = |req_valid_i;
    assign fifo_full  = (cnt_q == CntWidth'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);

    // Full is judged on the registered count only, so rvalid never reaches ready.
    assign mem_valid_o = any_valid && !fifo_full;
    assign push        = mem_valid_o && mem_ready_i;
    assign mem_we_o    = req_we_i[cand];
    assign mem_addr_o  = req_addr_i[cand*AddrWidth +: AddrWidth];
    assign mem_wdata_o = req_wdata_i[cand*DataWidth +: DataWidth];
    assign mem_be_o    = req_be_i[cand*BeWidth +: BeWidth];

    always_comb begin
        req_ready_o       = '0;
        req_ready_o[cand] = push;
    end

    assign head = ids_q[rd_ptr_q];
    assign pop  = mem_rvalid_i && !fifo_empty;

    always_comb begin
        rsp_valid_o       = '0;
        rsp_valid_o[head] = pop;
    end

    assign rsp_rdata_o    = mem_rdata_i;
    assign rsp_rerror_o   = pop ? mem_rerror_i : 2'b00;
    assign spurious_rsp_o = spurious_q;
    assign outstanding_o  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= mem_rvalid_i && fifo_empty;
            if (push) begin
                rr_q     <= (cand == IdWidth'(NumPorts - 1)) ? '0 : cand + 1'b1;
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ids_q[wr_ptr_q] <= cand;
        end
    end

endmodule

// File: tb/tb_spm_1p_arbiter.sv
// Bench for spm_1p_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a latency-1 SPM model.
module tb_spm_1p_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MO = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    req_we_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N*BW-1:0] req_be_i;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic [1:0]      rsp_rerror_o;
    logic            mem_valid_o;
    logic            mem_ready_i;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [BW-1:0]   mem_be_o;
    logic            mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;
    logic [1:0]      mem_rerror_i;
    logic            spurious_rsp_o;
    logic [CW-1:0]   outstanding_o;

    spm_1p_arbiter #(
        .NumPorts(N), .AddrWidth(AW), .DataWidth(DW),
        .BeWidth(BW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_rerror_o(rsp_rerror_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_rerror_i(mem_rerror_i),
        .spurious_rsp_o(spurious_rsp_o), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
        end
    endtask

    // ---------------- SPM model (latency 1) ----------------
    typedef struct {
        int         due;
        logic [31:0] d;
        logic [1:0]  e;
    } pend_t;

    pend_t       pq[$];
    logic [31:0] spm [512];
    logic        hold;
    logic        release_one;
    logic        inj;

    initial begin
        pend_t pe;
        for (int a = 0; a < 512; a++) spm[a] = 32'h0;
        for (int p = 0; p < N; p++) spm[16+p] = 32'hC0DE_0000 | p;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h5A5A_5A5A;
        mem_rerror_i = 2'b01;
        forever begin
            @(negedge clk);
            #2;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h5A5A_5A5A;
            mem_rerror_i = 2'b01;
            if (inj) begin
                mem_rvalid_i = 1'b1;
                mem_rerror_i = 2'b11;
            end else if (pq.size() > 0 && pq[0].due <= cyc_n
                         && (!hold || release_one)) begin
                pe = pq.pop_front();
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pe.d;
                mem_rerror_i = pe.e;
            end
            #2;
            if (mem_valid_o && mem_ready_i) begin
                pe.due = cyc_n + 1;
                if (mem_we_o) begin
                    for (int b = 0; b < BW; b++)
                        if (mem_be_o[b]) spm[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
                    pe.d = 32'h0;
                    pe.e = 2'b00;
                end else begin
                    pe.d = spm[mem_addr_o];
                    pe.e = mem_addr_o[1:0];
                end
                pq.push_back(pe);
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int   rr_m;
    int   q_m[$];
    logic spur_m;

    initial begin
        int          cand_m;
        bit          found, e_mv, hs, pp, nsp;
        logic [3:0]  one, e_rdy, e_rsp;
        one = 4'b0001;
        rr_m = 0;
        spur_m = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_ni) begin
                rr_m = 0;
                q_m.delete();
                spur_m = 1'b0;
            end
            cand_m = rr_m;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid_i[(rr_m + k) % N]) begin
                    cand_m = (rr_m + k) % N;
                    found = 1'b1;
                end
            end
            e_mv  = found && (q_m.size() < MO);
            e_rdy = (e_mv && mem_ready_i) ? (one << cand_m) : 4'b0000;
            e_rsp = (mem_rvalid_i && q_m.size() > 0) ? (one << q_m[0]) : 4'b0000;
            chk("mem_valid", 32'(mem_valid_o), 32'(e_mv));
            chk("req_ready", 32'(req_ready_o), 32'(e_rdy));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
            chk("outstanding", 32'(outstanding_o), 32'(q_m.size()));
            chk("spurious", 32'(spurious_rsp_o), 32'(spur_m));
            chk("rerror", 32'(rsp_rerror_o),
                (e_rsp != 4'b0000) ? 32'(mem_rerror_i) : 32'h0);
            if (e_mv) begin
                chk("mem_we", 32'(mem_we_o), 32'(req_we_i[cand_m]));
                chk("mem_addr", 32'(mem_addr_o), 32'(req_addr_i[cand_m*AW +: AW]));
                chk("mem_wdata", mem_wdata_o, req_wdata_i[cand_m*DW +: DW]);
                chk("mem_be", 32'(mem_be_o), 32'(req_be_i[cand_m*BW +: BW]));
            end
            if (e_rsp != 4'b0000) chk("rdata", rsp_rdata_o, mem_rdata_i);
            hs  = e_mv && mem_ready_i;
            pp  = (e_rsp != 4'b0000);
            nsp = mem_rvalid_i && (q_m.size() == 0);
            @(posedge clk);
            if (rst_ni) begin
                if (pp) void'(q_m.pop_front());
                if (hs) begin
                    q_m.push_back(cand_m);
                    rr_m = (cand_m + 1) % N;
                end
                spur_m = nsp;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be);
        req_valid_i[p]        = v;
        req_we_i[p]           = we;
        req_addr_i[p*AW +: AW] = a;
        req_wdata_i[p*DW +: DW] = d;
        req_be_i[p*BW +: BW]   = be;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((outstanding_o != '0 || pq.size() != 0) && i < 30) begin
            tick();
            i++;
        end
        #3;
        chk("drain_empty", 32'(outstanding_o), 32'h0);
        chk("drain_spm", 32'(pq.size()), 32'h0);
    endtask

    initial begin
        int sp_cnt;
        rst_ni = 1'b0;
        req_valid_i = '0;
        req_we_i = '0;
        req_addr_i = '0;
        req_wdata_i = '0;
        req_be_i = '0;
        mem_ready_i = 1'b0;
        hold = 1'b0;
        release_one = 1'b0;
        inj = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;

        // 1: idle after reset
        tick();
        #3;
        chk("t1_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("t1_ready", 32'(req_ready_o), 32'h0);
        chk("t1_rsp", 32'(rsp_valid_o), 32'h0);
        chk("t1_outstanding", 32'(outstanding_o), 32'h0);

        // 2: all ports read, round-robin 0,1,2,3,0
        tick();
        mem_ready_i = 1'b1;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, AW'(16 + p), 32'h0, 4'hF);
        #3;
        chk("t2_grant0", 32'(req_ready_o), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) req_valid_i = '0;
            #3;
            chk("t2_grant", 32'(req_ready_o), (k < 5) ? (32'h1 << (k % 4)) : 32'h0);
            chk("t2_rsp", 32'(rsp_valid_o), 32'h1 << ((k - 1) % 4));
            chk("t2_rdata", rsp_rdata_o, 32'hC0DE_0000 | ((k - 1) % 4));
            chk("t2_rerror", 32'(rsp_rerror_o), 32'((k - 1) % 4));
        end

        // 3: fill the ID FIFO, then one rvalid frees a slot a cycle later
        tick();
        hold = 1'b1;
        req_valid_i = '1;
        #3;
        chk("t3_grant", 32'(req_ready_o), 32'h2);
        for (int k = 1; k < 6; k++) begin
            tick();
            #3;
            chk("t3_grant", 32'(req_ready_o), (k < 4) ? (32'h1 << ((1 + k) % 4)) : 32'h0);
            if (k >= 4) chk("t3_full_cnt", 32'(outstanding_o), 32'(MO));
        end
        tick();
        release_one = 1'b1;
        #3;
        chk("t3_pop_ready", 32'(req_ready_o), 32'h0);
        chk("t3_pop_rsp", 32'(rsp_valid_o), 32'h2);
        tick();
        release_one = 1'b0;
        #3;
        chk("t3_resume", 32'(req_ready_o), 32'h2);
        chk("t3_resume_cnt", 32'(outstanding_o), 32'(MO - 1));
        tick();
        req_valid_i = '0;
        hold = 1'b0;
        drain();

        // 4: port 2 partial write, then port 1 reads it back
        tick();
        req_valid_i = '0;
        set_port(2, 1'b1, 1'b1, AW'(5), 32'hDEAD_BEEF, 4'b0011);
        set_port(1, 1'b1, 1'b0, AW'(5), 32'h0, 4'hF);
        #3;
        chk("t4_wr_grant", 32'(req_ready_o), 32'h4);
        chk("t4_wr_addr", 32'(mem_addr_o), 32'h5);
        tick();
        req_valid_i[2] = 1'b0;
        #3;
        chk("t4_rd_grant", 32'(req_ready_o), 32'h2);
        chk("t4_wr_rsp", 32'(rsp_valid_o), 32'h4);
        tick();
        req_valid_i = '0;
        #3;
        chk("t4_rd_rsp", 32'(rsp_valid_o), 32'h2);
        chk("t4_rdata", rsp_rdata_o, 32'h0000_BEEF);
        chk("t4_rerror", 32'(rsp_rerror_o), 32'h1);

        // 5: spurious response on empty FIFO
        tick();
        inj = 1'b1;
        #3;
        chk("t5_rsp", 32'(rsp_valid_o), 32'h0);
        chk("t5_rerror", 32'(rsp_rerror_o), 32'h0);
        tick();
        inj = 1'b0;
        #3;
        chk("t5_spur_hi", 32'(spurious_rsp_o), 32'h1);
        tick();
        #3;
        chk("t5_spur_lo", 32'(spurious_rsp_o), 32'h0);

        // 6: reset with 3 outstanding; late responses are spurious
        tick();
        hold = 1'b1;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, AW'(16 + p), 32'h0, 4'hF);
        #3;
        chk("t6_grant", 32'(req_ready_o), 32'h4);
        tick();
        tick();
        tick();
        req_valid_i = '0;
        #3;
        chk("t6_cnt3", 32'(outstanding_o), 32'h3);
        tick();
        rst_ni = 1'b0;
        #3;
        chk("t6_rst_cnt", 32'(outstanding_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        hold = 1'b0;
        sp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            #3;
            if (spurious_rsp_o) sp_cnt++;
            chk("t6_no_rsp", 32'(rsp_valid_o), 32'h0);
        end
        chk("t6_spur_count", 32'(sp_cnt), 32'h3);
        tick();
        req_valid_i = '1;
        #3;
        chk("t6_grant_p0", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = '0;
        drain();

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc_n);
        $fatal(1, "timeout");
    end

endmodule
